// File: rtl/apb_slave_regbank.sv
// APB register bank: fixed address window, byte-strobed 32-bit registers, a read-only ID
// register in the last slot, and a fixed number of wait states before each response.
module apb_slave_regbank #(
  parameter logic [31:0] BASE_ADDR   = 32'hA000,
  parameter int          NUM_REGS    = 16,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
  input  logic        clk,
  input  logic        preset,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  input  logic [3:0]  pstrb,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr
);

  localparam int              IW        = $clog2(NUM_REGS);
  localparam logic [31:0]     WIN_BYTES = 32'(4 * NUM_REGS);
  localparam logic [3:0]      WS        = 4'(WAIT_STATES);
  localparam logic [IW-1:0]   ID_IDX    = IW'(NUM_REGS - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [3:0]  strb_reg;
  logic        write_reg;
  logic [31:0] regs [NUM_REGS];

  logic [31:0]   dec_addr;
  logic [31:0]   offset;
  logic          dec_write;
  logic          dec_valid;
  logic          dec_err;
  logic [IW-1:0] dec_idx;
  logic [31:0]   resp_data;

  // While idle the bus itself is decoded so a zero-wait transfer can respond off its setup edge.
  always_comb begin
    dec_addr  = (state == S_IDLE) ? paddr  : addr_reg;
    dec_write = (state == S_IDLE) ? pwrite : write_reg;
    offset    = dec_addr - BASE_ADDR;
    dec_idx   = offset[IW+1:2];
    dec_valid = (dec_addr >= BASE_ADDR) && (offset < WIN_BYTES) && (dec_addr[1:0] == 2'b00);
    dec_err   = !dec_valid || (dec_write && (dec_idx == ID_IDX));
    resp_data = '0;
    if (!dec_err && !dec_write)
      resp_data = (dec_idx == ID_IDX) ? ID_VALUE : regs[dec_idx];
  end

  always_ff @(posedge clk) begin
    if (preset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      pready    <= 1'b0;
      prdata    <= '0;
      pslverr   <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      strb_reg  <= '0;
      write_reg <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          pready  <= 1'b0;
          prdata  <= '0;
          pslverr <= 1'b0;
          if (psel && !penable) begin
            addr_reg  <= paddr;
            wdata_reg <= pwdata;
            strb_reg  <= pstrb;
            write_reg <= pwrite;
            cnt       <= WS;
            if (WS == 4'd0) begin
              state   <= S_RESP;
              pready  <= 1'b1;
              prdata  <= resp_data;
              pslverr <= dec_err;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!psel) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else if (penable) begin
            if (cnt <= 4'd1) begin
              state   <= S_RESP;
              pready  <= 1'b1;
              prdata  <= resp_data;
              pslverr <= dec_err;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
        end
        S_RESP: begin
          state   <= S_IDLE;
          cnt     <= '0;
          pready  <= 1'b0;
          prdata  <= '0;
          pslverr <= 1'b0;
          // Commit at the end of the response cycle, only if the bridge kept the slave selected.
          if (psel && write_reg && dec_valid && (dec_idx != ID_IDX)) begin
            for (int b = 0; b < 4; b++)
              if (strb_reg[b])
                regs[dec_idx][8*b +: 8] <= wdata_reg[8*b +: 8];
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
